// File: rtl/edge_capture.sv
// Per-channel edge detector with optional synchroniser, sticky flags and a saturating event counter.
// Latency: a change sampled at edge N pulses after edge N+SYNC_STAGES; flag and cnt follow one cycle later.
// No backpressure: every input is sampled each cycle, and the counter saturates instead of wrapping.
module edge_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] edge_pulse,
    output logic [WIDTH-1:0] flag,
    output logic             any_flag,
    output logic [CNT_W-1:0] cnt
);

    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam int SW = CNT_W + $clog2(WIDTH) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] raw;
    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic [CNT_W-1:0] base;
    logic [SW-1:0]    sum;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= in;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        raw = '0;
        case (mode)
            2'b00:   raw = s & ~d;
            2'b01:   raw = ~s & d;
            2'b10:   raw = s ^ d;
            default: raw = '0;
        endcase
    end

    function automatic logic [SW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [SW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) acc = acc + SW'(v[i]);
        return acc;
    endfunction

    assign base = cnt_clr ? '0 : cnt;
    assign sum  = SW'(base) + popcnt(edge_pulse);

    // Arming waits until the synchroniser and d hold real samples, so a level
    // already present at reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
            armed   <= (arm_cnt == AW'(SYNC_STAGES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d          <= '0;
            edge_pulse <= '0;
            flag       <= '0;
            cnt        <= '0;
        end else begin
            d          <= s;
            edge_pulse <= raw & {WIDTH{armed}};
            flag       <= (flag & ~clr) | edge_pulse;
            cnt        <= (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    assign any_flag = |flag;

endmodule

// File: tb/tb_edge_capture.sv
// Bench for edge_capture: three instances cover no-synchroniser, two-stage synchroniser and narrow counter.
module tb_edge_capture;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // u0: SYNC_STAGES=0, u2: SYNC_STAGES=2, u4: SYNC_STAGES=0 with CNT_W=4
    logic [7:0]  in0, in2, in4, clr0, clr2, clr4;
    logic [1:0]  mode0, mode2, mode4;
    logic        cc0, cc2, cc4;
    logic [7:0]  ep0, ep2, ep4, fl0, fl2, fl4;
    logic        af0, af2, af4;
    logic [15:0] cn0, cn2;
    logic [3:0]  cn4;

    edge_capture #(.WIDTH(8), .SYNC_STAGES(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in(in0), .mode(mode0), .clr(clr0), .cnt_clr(cc0),
        .edge_pulse(ep0), .flag(fl0), .any_flag(af0), .cnt(cn0));
    edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .mode(mode2), .clr(clr2), .cnt_clr(cc2),
        .edge_pulse(ep2), .flag(fl2), .any_flag(af2), .cnt(cn2));
    edge_capture #(.WIDTH(8), .SYNC_STAGES(0), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .mode(mode4), .clr(clr4), .cnt_clr(cc4),
        .edge_pulse(ep4), .flag(fl4), .any_flag(af4), .cnt(cn4));

    typedef struct {
        logic [7:0]  in;
        logic [1:0]  mode;
        logic [7:0]  clr;
        logic        cc;
        logic [7:0]  ep;
        logic [7:0]  fl;
        logic [15:0] cn;
    } vec_t;

    vec_t tbl [18];
    vec_t sb_q [$];
    vec_t got;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four-cycle window for u2: pulse may only appear after the third edge.
    task automatic run_lat(input string nm, input logic [7:0] exp);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("%s_c%0d", nm, k), {24'd0, ep2}, (k == 3) ? {24'd0, exp} : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{8'h00, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0};
        tbl[1]  = '{8'h90, 2'b00, 8'h00, 1'b0, 8'h90, 8'h00, 16'd0};
        tbl[2]  = '{8'h94, 2'b00, 8'h00, 1'b0, 8'h04, 8'h90, 16'd2};
        tbl[3]  = '{8'h94, 2'b00, 8'h00, 1'b0, 8'h00, 8'h94, 16'd3};
        tbl[4]  = '{8'h84, 2'b00, 8'h00, 1'b0, 8'h00, 8'h94, 16'd3};
        tbl[5]  = '{8'h94, 2'b00, 8'h00, 1'b0, 8'h10, 8'h94, 16'd3};
        tbl[6]  = '{8'h94, 2'b00, 8'h10, 1'b0, 8'h00, 8'h94, 16'd4};
        tbl[7]  = '{8'h94, 2'b00, 8'h10, 1'b0, 8'h00, 8'h84, 16'd4};
        tbl[8]  = '{8'h00, 2'b11, 8'h00, 1'b0, 8'h00, 8'h84, 16'd4};
        tbl[9]  = '{8'hFF, 2'b11, 8'h00, 1'b0, 8'h00, 8'h84, 16'd4};
        tbl[10] = '{8'hFF, 2'b00, 8'h00, 1'b0, 8'h00, 8'h84, 16'd4};
        tbl[11] = '{8'h0F, 2'b10, 8'h00, 1'b0, 8'hF0, 8'h84, 16'd4};
        tbl[12] = '{8'h0F, 2'b10, 8'h00, 1'b0, 8'h00, 8'hF4, 16'd8};
        tbl[13] = '{8'h0E, 2'b01, 8'h00, 1'b0, 8'h01, 8'hF4, 16'd8};
        tbl[14] = '{8'h0E, 2'b01, 8'h00, 1'b0, 8'h00, 8'hF5, 16'd9};
        tbl[15] = '{8'h0F, 2'b00, 8'h00, 1'b0, 8'h01, 8'hF5, 16'd9};
        tbl[16] = '{8'h0F, 2'b00, 8'h00, 1'b1, 8'h00, 8'hF5, 16'd1};
        tbl[17] = '{8'h0F, 2'b00, 8'h00, 1'b1, 8'h00, 8'hF5, 16'd0};

        rst_n = 1'b1;
        in0 = 8'h00; mode0 = 2'b00; clr0 = 8'h00; cc0 = 1'b0;
        in2 = 8'hFF; mode2 = 2'b00; clr2 = 8'h00; cc2 = 1'b0;
        in4 = 8'h00; mode4 = 2'b10; clr4 = 8'h00; cc4 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_ep0", {24'd0, ep0}, 32'd0);
        chk("rst_fl0", {24'd0, fl0}, 32'd0);
        chk("rst_af0", {31'd0, af0}, 32'd0);
        chk("rst_cn0", {16'd0, cn0}, 32'd0);
        chk("rst_ep2", {24'd0, ep2}, 32'd0);
        #3 rst_n = 1'b1;

        // in2 held high through release: no pulse may escape the disarm window
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("hold_ep2_%0d", k), {24'd0, ep2}, 32'd0);
        end
        chk("hold_fl2", {24'd0, fl2}, 32'd0);
        chk("hold_cn2", {16'd0, cn2}, 32'd0);

        // Table-driven run on u0 through a scoreboard queue
        for (int i = 0; i < 18; i++) begin
            in0 = tbl[i].in; mode0 = tbl[i].mode; clr0 = tbl[i].clr; cc0 = tbl[i].cc;
            sb_q.push_back(tbl[i]);
            step();
            got = sb_q.pop_front();
            chk($sformatf("t%0d_ep", i), {24'd0, ep0}, {24'd0, got.ep});
            chk($sformatf("t%0d_fl", i), {24'd0, fl0}, {24'd0, got.fl});
            chk($sformatf("t%0d_af", i), {31'd0, af0}, {31'd0, |got.fl});
            chk($sformatf("t%0d_cn", i), {16'd0, cn0}, {16'd0, got.cn});
        end
        clr0 = 8'h00; cc0 = 1'b0;

        // u2 latency: falling edges after held-high release
        mode2 = 2'b01; in2 = 8'h00;
        run_lat("fall_ff", 8'hFF);
        chk("fall_cn2", {16'd0, cn2}, 32'd8);
        chk("fall_fl2", {24'd0, fl2}, 32'hFF);
        in2 = 8'hFF;
        run_lat("rise_ignored", 8'h00);
        in2 = 8'h0F;
        run_lat("fall_f0", 8'hF0);
        chk("f0_cn2", {16'd0, cn2}, 32'd12);
        mode2 = 2'b10; in2 = 8'hF0;
        run_lat("both_ff", 8'hFF);
        chk("both_cn2", {16'd0, cn2}, 32'd20);

        // u4 narrow counter saturation
        in4 = 8'hFF; step();
        chk("sat_ep4", {24'd0, ep4}, 32'hFF);
        chk("sat_cn4_0", {28'd0, cn4}, 32'd0);
        in4 = 8'h00; step();
        chk("sat_cn4_8", {28'd0, cn4}, 32'd8);
        in4 = 8'hFF; step();
        chk("sat_cn4_15a", {28'd0, cn4}, 32'd15);
        in4 = 8'h00; step();
        chk("sat_cn4_15b", {28'd0, cn4}, 32'd15);
        in4 = 8'hFF; cc4 = 1'b1; step();
        chk("clr_cn4_8", {28'd0, cn4}, 32'd8);
        cc4 = 1'b0; step();
        chk("resat_cn4", {28'd0, cn4}, 32'd15);

        // Asynchronous reset in the middle of a live pulse
        mode0 = 2'b10; in0 = 8'hF0; step();
        chk("pre_rst_ep0", {24'd0, ep0}, 32'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ep0", {24'd0, ep0}, 32'd0);
        chk("arst_fl0", {24'd0, fl0}, 32'd0);
        chk("arst_af0", {31'd0, af0}, 32'd0);
        chk("arst_cn0", {16'd0, cn0}, 32'd0);
        chk("arst_cn2", {16'd0, cn2}, 32'd0);
        chk("arst_cn4", {28'd0, cn4}, 32'd0);
        #10 rst_n = 1'b1;
        mode0 = 2'b11;
        for (int k = 0; k < 8; k++) begin
            in0 = ~in0;
            step();
            chk($sformatf("dis_ep0_%0d", k), {24'd0, ep0}, 32'd0);
            chk($sformatf("dis_fl0_%0d", k), {23'd0, af0, fl0}, 32'd0);
            chk($sformatf("dis_cn0_%0d", k), {16'd0, cn0}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
